// File: rtl/hex_pb_pkg.sv
// Shared constants and helpers for the HEX/LED display + pushbutton Avalon-MM slave.
package hex_pb_pkg;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned ADDR_W      = 2;
   localparam int unsigned NUM_BUTTONS = 4;
   localparam int unsigned CNT_W       = 24;
   localparam int unsigned BYTES       = DATA_W / 8;

   localparam logic [ADDR_W-1:0] REG_DISPLAY = 2'd0;
   localparam logic [ADDR_W-1:0] REG_LEVEL   = 2'd1;
   localparam logic [ADDR_W-1:0] REG_EDGE    = 2'd2;
   localparam logic [ADDR_W-1:0] REG_MASK    = 2'd3;

   // Merge new data into old data on the enabled byte lanes only.
   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_data,
                                                     input logic [DATA_W-1:0] new_data,
                                                     input logic [BYTES-1:0]  be);
      logic [DATA_W-1:0] res;
      res = old_data;
      for (int i = 0; i < int'(BYTES); i++) begin
         if (be[i]) res[i*8 +: 8] = new_data[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/hex_pb_avalon_slave_pb_debounce.sv
// One pushbutton: 2-flop synchronizer, saturating stability counter and debounced
// active-high pressed state; press_c pulses on the edge where a press is accepted.
module pb_debounce
   import hex_pb_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_n,
   output logic pressed,
   output logic press_c
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic             differ_c;
   logic             done_c;

   // sync2 is active-low, pressed is active-high, so equality means disagreement
   assign differ_c = (sync2 == pressed);
   assign done_c   = differ_c && (cnt == LAST);
   assign press_c  = done_c && !sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         cnt     <= '0;
         pressed <= 1'b0;
      end else begin
         sync1 <= button_n;
         sync2 <= sync1;
         if (!differ_c) begin
            cnt <= '0;
         end else if (done_c) begin
            pressed <= !sync2;
            cnt     <= '0;
         end else if (cnt < LAST) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/hex_pb_avalon_slave.sv
// Avalon-MM slave: display word for the HEX/LED decoder plus debounced pushbuttons
// with level, sticky press-edge (W1C), mask and level interrupt.
module hex_pb_avalon_slave
   import hex_pb_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic                   clk_clk,
   input  logic                   reset_reset_n,
   input  logic [ADDR_W-1:0]      avs_address,
   input  logic                   avs_read,
   input  logic                   avs_write,
   input  logic [DATA_W-1:0]      avs_writedata,
   input  logic [BYTES-1:0]       avs_byteenable,
   output logic [DATA_W-1:0]      avs_readdata,
   output logic                   avs_readdatavalid,
   output logic                   irq,
   input  logic [NUM_BUTTONS-1:0] pushbutton_export,
   output logic [DATA_W-1:0]      to_hex_to_led_readdata
);

   logic [DATA_W-1:0]      display_q;
   logic [NUM_BUTTONS-1:0] level;
   logic [NUM_BUTTONS-1:0] press_c;
   logic [NUM_BUTTONS-1:0] edge_q;
   logic [NUM_BUTTONS-1:0] mask_q;
   logic [NUM_BUTTONS-1:0] clr_c;
   logic [DATA_W-1:0]      rd_mux_c;
   logic                   wr_lane0_c;

   for (genvar i = 0; i < int'(NUM_BUTTONS); i++) begin : g_pb
      pb_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_pb (
         .clk     (clk_clk),
         .rst_n   (reset_reset_n),
         .button_n(pushbutton_export[i]),
         .pressed (level[i]),
         .press_c (press_c[i])
      );
   end

   assign to_hex_to_led_readdata = display_q;
   assign wr_lane0_c = avs_write && avs_byteenable[0];
   assign clr_c = (wr_lane0_c && (avs_address == REG_EDGE)) ?
                  avs_writedata[NUM_BUTTONS-1:0] : '0;

   // Read mux sees pre-write register values, so a simultaneous read returns old data
   always_comb begin
      rd_mux_c = '0;
      case (avs_address)
         REG_DISPLAY: rd_mux_c = display_q;
         REG_LEVEL:   rd_mux_c = DATA_W'(level);
         REG_EDGE:    rd_mux_c = DATA_W'(edge_q);
         REG_MASK:    rd_mux_c = DATA_W'(mask_q);
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         display_q         <= '0;
         edge_q            <= '0;
         mask_q            <= '0;
         irq               <= 1'b0;
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
      end else begin
         avs_readdatavalid <= avs_read;
         avs_readdata      <= avs_read ? rd_mux_c : '0;
         if (avs_write && (avs_address == REG_DISPLAY)) begin
            display_q <= merge_bytes(display_q, avs_writedata, avs_byteenable);
         end
         if (wr_lane0_c && (avs_address == REG_MASK)) begin
            mask_q <= avs_writedata[NUM_BUTTONS-1:0];
         end
         // A press accepted on the same edge as a clearing write wins
         edge_q <= (edge_q & ~clr_c) | press_c;
         irq    <= |(edge_q & mask_q);
      end
   end

endmodule
